// File: rtl/version_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// version_bank : build-ID register bank (git hash + timestamp per repo) with
//                XOR checksum, random reads and a streamed dump.
// Revision     : 1.0
// ----------------------------------------------------------------------------

// Behavioural stand-ins for the patchable init cells; the real cell values
// are rewritten after implementation.
module user_init_64b #(
   parameter logic [63:0] INIT_VALUE = 64'h0
) (
   input  logic        clk,
   output logic [63:0] value
);
   logic unused_clk;
   assign unused_clk = clk;
   assign value      = INIT_VALUE;
endmodule

module user_init_32b #(
   parameter logic [31:0] INIT_VALUE = 32'h0
) (
   input  logic        clk,
   output logic [31:0] value
);
   logic unused_clk;
   assign unused_clk = clk;
   assign value      = INIT_VALUE;
endmodule

module version_bank #(
   parameter int  NUM_REPOS = 5,
   parameter int  USE_INIT  = 1,
   localparam int NW        = 4*NUM_REPOS+1,
   localparam int AW        = $clog2(NW)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [64*NUM_REPOS-1:0]  hash_i,
   input  logic [32*NUM_REPOS-1:0]  ts_i,
   output logic                     init_done,
   input  logic                     rd_req,
   input  logic [AW-1:0]            rd_addr,
   output logic                     rd_ready,
   output logic                     rd_valid,
   output logic [31:0]              rd_data,
   output logic                     rd_err,
   input  logic                     dump_start,
   output logic                     dump_busy,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [31:0]              m_data,
   output logic                     m_last
);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_DUMP = 2'd2
   } state_t;

   localparam logic [AW-1:0] LAST_DATA = AW'(NW-2);
   localparam logic [AW-1:0] LAST_WORD = AW'(NW-1);

   state_t        state, state_next;
   logic [AW-1:0] cnt, cnt_next;
   logic [31:0]   acc, acc_next;
   logic [31:0]   checksum, checksum_next;
   logic          init_done_next;
   logic [31:0]   words [NW];
   logic          rd_accept;
   logic          rd_in_range;

   for (genvar r = 0; r < NUM_REPOS; r++) begin : g_repo
      logic [63:0] hash;
      logic [31:0] ts;
      if (USE_INIT != 0) begin : g_init
         user_init_64b u_hash (.clk(1'b0), .value(hash));
         user_init_32b u_ts   (.clk(1'b0), .value(ts));
      end else begin : g_port
         assign hash = hash_i[64*r +: 64];
         assign ts   = ts_i[32*r +: 32];
      end
      assign words[4*r]   = hash[31:0];
      assign words[4*r+1] = hash[63:32];
      assign words[4*r+2] = ts;
      assign words[4*r+3] = {8'hA5, 8'h00, 8'(r), 8'(NUM_REPOS)};
   end

   if (USE_INIT != 0) begin : g_unused
      logic unused_ports;
      assign unused_ports = ^{hash_i, ts_i};
   end

   assign words[NW-1] = checksum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_INIT;
         cnt       <= '0;
         acc       <= '0;
         checksum  <= '0;
         init_done <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         acc       <= acc_next;
         checksum  <= checksum_next;
         init_done <= init_done_next;
      end
   end

   // The word counter doubles as the dump pointer once init has finished.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      acc_next       = acc;
      checksum_next  = checksum;
      init_done_next = init_done;
      case (state)
         ST_INIT: begin
            acc_next = acc ^ words[cnt];
            if (cnt == LAST_DATA) begin
               checksum_next  = acc ^ words[cnt];
               init_done_next = 1'b1;
               cnt_next       = '0;
               state_next     = ST_IDLE;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            if (dump_start) begin
               cnt_next   = '0;
               state_next = ST_DUMP;
            end
         end
         ST_DUMP: begin
            if (m_ready) begin
               if (cnt == LAST_WORD) begin
                  cnt_next   = '0;
                  state_next = ST_IDLE;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
         end
         default: state_next = ST_INIT;
      endcase
   end

   assign dump_busy = (state == ST_DUMP);
   assign rd_ready  = init_done & ~dump_busy;
   assign m_valid   = dump_busy;
   assign m_data    = dump_busy ? words[cnt] : 32'h0;
   assign m_last    = dump_busy && (cnt == LAST_WORD);

   assign rd_accept   = rd_req & rd_ready;
   assign rd_in_range = (rd_addr <= LAST_WORD);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= 32'h0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_accept;
         rd_err   <= rd_accept & ~rd_in_range;
         if (rd_accept) begin
            rd_data <= rd_in_range ? words[rd_addr] : 32'hDEAD_BEEF;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_version_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_version_bank : self-checking bench for version_bank (2 repos, port-fed).
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_version_bank;

   localparam int N  = 2;
   localparam int NW = 4*N+1;
   localparam int AW = $clog2(NW);
   localparam int NV = 11;

   logic            clk = 1'b0;
   logic            rst;
   logic [64*N-1:0] hash_i;
   logic [32*N-1:0] ts_i;
   logic            init_done;
   logic            rd_req;
   logic [AW-1:0]   rd_addr;
   logic            rd_ready;
   logic            rd_valid;
   logic [31:0]     rd_data;
   logic            rd_err;
   logic            dump_start;
   logic            dump_busy;
   logic            m_valid;
   logic            m_ready;
   logic [31:0]     m_data;
   logic            m_last;

   always #5 clk = ~clk;

   version_bank #(.NUM_REPOS(N), .USE_INIT(0)) dut (
      .clk(clk), .rst(rst), .hash_i(hash_i), .ts_i(ts_i),
      .init_done(init_done), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_err(rd_err), .dump_start(dump_start), .dump_busy(dump_busy),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic          err;
   } rd_vec_t;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic [63:0] hashes [N] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
   logic [31:0] stamps [N] = '{32'h6600_0001, 32'h6600_0002};
   rd_vec_t     vecs [NV];
   exp_t        sb [$];
   int          vectors     = 0;
   int          miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] data_word(input int w);
      int r;
      r = w / 4;
      case (w % 4)
         0:       return hashes[r][31:0];
         1:       return hashes[r][63:32];
         2:       return stamps[r];
         default: return {8'hA5, 8'h00, 8'(r), 8'(N)};
      endcase
   endfunction

   function automatic logic [31:0] model_word(input int w);
      logic [31:0] x;
      if (w < NW-1) return data_word(w);
      x = 32'h0;
      for (int i = 0; i < NW-1; i++) x = x ^ data_word(i);
      return x;
   endfunction

   // Read results arrive in order; each rd_valid consumes one expectation.
   always @(negedge clk) begin
      if (rd_valid) begin : mon
         exp_t e;
         if (sb.size() == 0) begin
            check("rd_valid_unexpected", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("rd_data", rd_data, e.data);
            check("rd_err", rd_err, e.err);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_flags"}, {57'd0, init_done, rd_ready, rd_valid, rd_err,
                              dump_busy, m_valid, m_last}, 64'd0);
      check({tag, "_data"}, {rd_data, m_data}, 64'd0);
   endtask

   // Called just after rst is lowered; a read issued during INIT must vanish.
   task automatic run_init(input string tag);
      for (int i = 1; i <= NW-1; i++) begin
         if (i == 2) begin
            rd_req  = 1'b1;
            rd_addr = AW'(3);
         end
         if (i == 4) rd_req = 1'b0;
         tick();
         check({tag, "_init_done"}, init_done, 64'(i == NW-1));
      end
   endtask

   task automatic check_drain(input string tag);
      tick();
      tick();
      check({tag, "_sb_empty"}, sb.size(), 64'd0);
   endtask

   task automatic start_dump();
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      check("dump_busy_start", dump_busy, 64'd1);
      check("rd_ready_in_dump", rd_ready, 64'd0);
   endtask

   // Streams until stop_hs handshakes have completed, checking every cycle.
   task automatic dump_stream(input int stop_hs, input bit hammer);
      int  k    = 0;
      int  cyc  = 0;
      bit  done = 1'b0;
      while (!done && cyc < 400) begin
         check("m_valid", m_valid, 64'd1);
         check("m_data", m_data, model_word(k));
         check("m_last", m_last, 64'(k == NW-1));
         m_ready = 1'($urandom_range(0, 1));
         rd_req  = hammer;
         rd_addr = AW'(2);
         if (m_ready && m_valid) begin
            k++;
            if (k == stop_hs) begin
               done   = 1'b1;
               rd_req = 1'b0;
            end
         end
         tick();
         cyc++;
      end
      m_ready = 1'b0;
      rd_req  = 1'b0;
      if (!done) check("dump_timeout", 64'd1, 64'd0);
   endtask

   task automatic check_dump_end(input string tag);
      check({tag, "_end"}, {61'd0, m_valid, dump_busy, rd_ready}, 64'b001);
   endtask

   initial begin
      vecs[0]  = '{AW'(1),  32'h0123_4567, 1'b0};
      vecs[1]  = '{AW'(2),  32'h6600_0001, 1'b0};
      vecs[2]  = '{AW'(7),  32'hA500_0102, 1'b0};
      vecs[3]  = '{AW'(9),  32'hDEAD_BEEF, 1'b1};
      vecs[4]  = '{AW'(15), 32'hDEAD_BEEF, 1'b1};
      vecs[5]  = '{AW'(0),  32'h89AB_CDEF, 1'b0};
      vecs[6]  = '{AW'(3),  32'hA500_0002, 1'b0};
      vecs[7]  = '{AW'(4),  32'h7654_3210, 1'b0};
      vecs[8]  = '{AW'(5),  32'hFEDC_BA98, 1'b0};
      vecs[9]  = '{AW'(6),  32'h6600_0002, 1'b0};
      vecs[10] = '{AW'(8),  32'h0000_0103, 1'b0};

      rst        = 1'b1;
      rd_req     = 1'b0;
      rd_addr    = '0;
      dump_start = 1'b0;
      m_ready    = 1'b0;
      hash_i     = {hashes[1], hashes[0]};
      ts_i       = {stamps[1], stamps[0]};
      tick();
      tick();
      check_reset_outputs("reset");

      rst = 1'b0;
      run_init("init");

      rd_req  = 1'b1;
      rd_addr = AW'(8);
      sb.push_back('{32'h0000_0103, 1'b0});
      tick();
      rd_req = 1'b0;
      check("rd8_latency", rd_valid, 64'd1);
      check_drain("rd8");

      for (int i = 0; i < NV; i++) begin
         rd_req  = 1'b1;
         rd_addr = vecs[i].addr;
         sb.push_back('{vecs[i].data, vecs[i].err});
         tick();
         check("b2b_valid", rd_valid, 64'd1);
      end
      rd_req = 1'b0;
      tick();
      check("rd_valid_drop", rd_valid, 64'd0);
      check_drain("table");

      start_dump();
      dump_stream(NW, 1'b0);
      check_dump_end("dump1");

      rd_req     = 1'b1;
      rd_addr    = AW'(0);
      dump_start = 1'b1;
      sb.push_back('{32'h89AB_CDEF, 1'b0});
      tick();
      rd_req     = 1'b0;
      dump_start = 1'b0;
      check("simul_rd_valid", rd_valid, 64'd1);
      check("simul_dump_busy", dump_busy, 64'd1);
      check("simul_rd_ready", rd_ready, 64'd0);
      dump_stream(NW, 1'b1);
      check_dump_end("dump2");
      check_drain("simul");

      start_dump();
      dump_stream(4, 1'b0);
      rst     = 1'b1;
      rd_req  = 1'b1;
      rd_addr = AW'(1);
      tick();
      rd_req = 1'b0;
      check_reset_outputs("midreset");
      rst = 1'b0;
      run_init("reinit");
      start_dump();
      dump_stream(NW, 1'b0);
      check_dump_end("dump3");
      check_drain("final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/version_bank.md
# version_bank

Parametrised build-identification register bank holding a git hash and a build timestamp for each of NUM_REPOS source repositories. Values come from post-implementation-patchable user_init_64b/user_init_32b cells, or from input ports for simulation. After reset the block computes an XOR checksum over all words. It then serves single-word random reads and a full streamed dump with valid/ready backpressure to the control-register or debug-UART layer.

## Interface
- NUM_REPOS, 5, number of repositories; range 1..63.
- USE_INIT, 1, 1: values come from internal user_init_64b/user_init_32b instances, one pair per repo, clk tied 1'b0. 0: values come from hash_i/ts_i.
- Derived: NW = 4*NUM_REPOS+1 words; AW = $clog2(NW).
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- hash_i  in  64*NUM_REPOS  repo r hash at [64r+63:64r]; ignored when USE_INIT=1.
- ts_i  in  32*NUM_REPOS  repo r timestamp at [32r+31:32r]; ignored when USE_INIT=1.
- init_done  out  1  checksum valid; bank serviceable.
- rd_req  in  1  read request.
- rd_addr  in  AW  word index.
- rd_ready  out  1  = init_done & !dump_busy.
- rd_valid  out  1  one-cycle read-data strobe.
- rd_data  out  32  read word.
- rd_err  out  1  address out of range; qualified by rd_valid.
- dump_start  in  1  request full stream-out.
- dump_busy  out  1  dump in progress.
- m_valid  out  1  stream word valid.
- m_ready  in  1  stream sink ready.
- m_data  out  32  stream word.
- m_last  out  1  final word (checksum).

## Operation
- Word map, w = 4r+k:
  - k=0: hash[31:0]
  - k=1: hash[63:32]
  - k=2: timestamp
  - k=3: {8'hA5, 8'h00, 8'(r), 8'(NUM_REPOS)}
- w = 4*NUM_REPOS: checksum, the XOR of all words 0..4*NUM_REPOS-1.
- FSM states INIT, IDLE, DUMP.
  - rst forces INIT, with word counter 0 and accumulator 0.
  - INIT XORs one word per cycle. After word 4*NUM_REPOS-1 it latches the checksum, sets init_done and moves to IDLE.
  - IDLE→DUMP on dump_start. dump_start is ignored when not in IDLE.
  - DUMP→IDLE after the m_last handshake.
- Read path, independent of the FSM:
  - Accepted when rd_req & rd_ready.
  - rd_addr < NW: rd_data = word, rd_err = 0.
  - rd_addr >= NW: rd_data = 32'hDEAD_BEEF, rd_err = 1.
  - rd_req while !rd_ready is dropped; no rd_valid is produced.
- Simultaneous rd_req and dump_start in IDLE: the read is accepted and completes; the dump also starts.
- Dump: words are streamed in order 0..NW-1. m_last = 1 only on word NW-1.

## Timing
- Reset values: init_done, rd_ready, rd_valid, rd_err, dump_busy, m_valid and m_last are 0; rd_data and m_data are 0.
- Init latency: the first cycle with rst low is INIT cycle 0. init_done = 1 from cycle 4*NUM_REPOS onward.
- Read latency is 1 cycle: rd_valid is high exactly one cycle after the accept. Back-to-back accepts give one result per cycle.
- Dump start:
  - dump_busy = 1 from the cycle after dump_start acceptance.
  - m_valid is high with word 0 in that same cycle.
- Dump handshake and backpressure:
  - m_valid & m_ready advances to the next word in the following cycle.
  - While m_ready = 0, m_valid, m_data and m_last hold stable.
  - m_valid never drops before its handshake.
- Dump end: the cycle after the last handshake has m_valid = 0 and dump_busy = 0. rd_ready is back to 1 in that cycle.
- rst asserted mid-dump or mid-read:
  - Next cycle all outputs are at their reset values and any pending rd_valid is lost.
  - INIT reruns from word 0.
- Input sampling:
  - With USE_INIT=0, hash_i/ts_i are sampled live; a change after init makes the checksum stale by design.
  - With USE_INIT=1 the values are constant.

## Test plan
Common setup: NUM_REPOS=2, USE_INIT=0, hash0=64'h0123_4567_89AB_CDEF, ts0=32'h6600_0001, hash1=64'hFEDC_BA98_7654_3210, ts1=32'h6600_0002.
- Init: release rst → init_done rises exactly 8 cycles later. Read addr 8 → rd_data=32'h0000_0103, rd_err=0.
- Random reads: addr 1,2,7 in consecutive cycles → rd_valid on 3 consecutive cycles, rd_data = 32'h0123_4567, 32'h6600_0001, 32'hA500_0102.
- Out of range: addr 9 and addr 15 → rd_data=32'hDEAD_BEEF, rd_err=1. A request during INIT → no rd_valid.
- Dump with backpressure: m_ready toggled pseudo-randomly → 9 words equal to the map above, stable under stall. m_last only on 32'h0000_0103. dump_busy falls the cycle after that handshake.
- Simultaneous events: rd_req(addr 0) and dump_start in the same IDLE cycle → rd_data=32'h89AB_CDEF next cycle and the dump starts. rd_ready is 0 while the dump is active.
- Reset mid-dump: assert rst after 4 handshakes → all outputs return to reset values. After release, init_done is back 8 cycles later and a new dump starts at word 0.
